lmsm_sequencer: RTL and testbench

- Sits between the IF/ID pipeline register and the register-read stage.
- Expands each LM/SM instruction into one micro-op per set bit of its 8-bit register mask, lowest bit first.
- Holds fetch while expansion is in progress. Passes every other instruction through unchanged with one cycle of latency.
- The hazard detection unit consumes out_ir/out_first and drives id_stall/flush back into this block.

---
 rtl/lmsm_pkg.sv | 19 +
 rtl/lsb_pri_enc.sv | 24 ++
 rtl/lmsm_sequencer.sv | 177 +++++++++++++++++
 tb/tb_lmsm_sequencer.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/lmsm_pkg.sv
// Shared types and constants for the LM/SM micro-op sequencer.
package lmsm_pkg;

   localparam int unsigned IR_W   = 16;
   localparam int unsigned MASK_W = 8;

   localparam logic [3:0] OPC_LM = 4'b0110;
   localparam logic [3:0] OPC_SM = 4'b0111;

   typedef enum logic [0:0] {
      StIdle,
      StSeq
   } state_e;

   function automatic logic is_multi(input logic [3:0] opcode);
      return (opcode == OPC_LM) || (opcode == OPC_SM);
   endfunction

endpackage

// File: rtl/lsb_pri_enc.sv
// Lowest-set-bit priority encoder: index, one-hot, any-set and two-or-more-set flags.
module lsb_pri_enc
   import lmsm_pkg::*;
(
   input  logic [MASK_W-1:0] mask,
   output logic [2:0]        idx,
   output logic [MASK_W-1:0] onehot,
   output logic              any,
   output logic              multi
);

   always_comb begin
      idx = 3'd0;
      // Scan downwards so the lowest set bit is the last one written.
      for (int i = MASK_W - 1; i >= 0; i--) begin
         if (mask[i]) idx = 3'(i);
      end
   end

   assign onehot = mask & (~mask + 1'b1);
   assign any    = |mask;
   assign multi  = |(mask & (mask - 1'b1));

endmodule

// File: rtl/lmsm_sequencer.sv
// Expands LM/SM instructions into one micro-op per mask bit; passes other instructions through.
// Optional LMSM_PERF_EN adds a saturating perf_count of emitted LM/SM micro-ops.
module lmsm_sequencer
   import lmsm_pkg::*;
(
   input  logic            clk,
   input  logic            rst_n,
   input  logic            in_valid,
   input  logic [IR_W-1:0] in_ir,
   input  logic [IR_W-1:0] in_pc,
   input  logic            id_stall,
   input  logic            flush,
   output logic            out_valid,
   output logic [IR_W-1:0] out_ir,
   output logic [IR_W-1:0] out_pc,
   output logic [2:0]      out_reg,
   output logic [2:0]      out_offset,
   output logic            out_first,
   output logic            out_last,
   output logic            hold_fetch,
   output logic            busy
`ifdef LMSM_PERF_EN
   ,
   output logic [15:0]     perf_count
`endif
);

   state_e              state_q, state_d;
   logic [MASK_W-1:0]   rem_q, rem_d;
   logic [2:0]          cnt_q, cnt_d;

   logic                valid_q, valid_d;
   logic [IR_W-1:0]     ir_q, ir_d;
   logic [IR_W-1:0]     pc_q, pc_d;
   logic [2:0]          reg_q, reg_d;
   logic [2:0]          off_q, off_d;
   logic                first_q, first_d;
   logic                last_q, last_d;

   logic [MASK_W-1:0]   enc_in;
   logic [2:0]          enc_idx;
   logic [MASK_W-1:0]   enc_onehot;
   logic                enc_any;
   logic                enc_multi;
   logic                start;
   logic                in_multi;

   assign start    = in_valid && (state_q == StIdle);
   assign in_multi = is_multi(in_ir[15:12]);
   assign enc_in   = (state_q == StIdle) ? in_ir[MASK_W-1:0] : rem_q;

   lsb_pri_enc u_enc (
      .mask   (enc_in),
      .idx    (enc_idx),
      .onehot (enc_onehot),
      .any    (enc_any),
      .multi  (enc_multi)
   );

   // Released one cycle early so IF/ID presents the next instruction alongside the last micro-op.
   assign hold_fetch = id_stall
                     || (start && in_multi && enc_multi)
                     || ((state_q == StSeq) && enc_multi);

   always_comb begin
      state_d = state_q;
      rem_d   = rem_q;
      cnt_d   = cnt_q;
      valid_d = valid_q;
      ir_d    = ir_q;
      pc_d    = pc_q;
      reg_d   = reg_q;
      off_d   = off_q;
      first_d = first_q;
      last_d  = last_q;

      if (flush) begin
         state_d = StIdle;
         rem_d   = '0;
         cnt_d   = '0;
         valid_d = 1'b0;
      end else if (!id_stall) begin
         unique case (state_q)
            StIdle: begin
               if (start) begin
                  valid_d = 1'b1;
                  pc_d    = in_pc;
                  first_d = 1'b1;
                  off_d   = 3'd0;
                  if (in_multi && enc_any) begin
                     ir_d    = {in_ir[IR_W-1:MASK_W], enc_onehot};
                     reg_d   = enc_idx;
                     last_d  = !enc_multi;
                     rem_d   = in_ir[MASK_W-1:0] & ~enc_onehot;
                     cnt_d   = 3'd1;
                     state_d = enc_multi ? StSeq : StIdle;
                  end else begin
                     ir_d   = in_ir;
                     reg_d  = in_ir[11:9];
                     last_d = 1'b1;
                     rem_d  = '0;
                     cnt_d  = '0;
                  end
               end else begin
                  valid_d = 1'b0;
               end
            end
            StSeq: begin
               valid_d = 1'b1;
               ir_d    = {ir_q[IR_W-1:MASK_W], enc_onehot};
               reg_d   = enc_idx;
               off_d   = cnt_q;
               first_d = 1'b0;
               last_d  = !enc_multi;
               rem_d   = rem_q & ~enc_onehot;
               cnt_d   = cnt_q + 3'd1;
               if (!enc_multi) state_d = StIdle;
            end
            default: state_d = StIdle;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
         rem_q   <= '0;
         cnt_q   <= '0;
         valid_q <= 1'b0;
         ir_q    <= '0;
         pc_q    <= '0;
         reg_q   <= '0;
         off_q   <= '0;
         first_q <= 1'b0;
         last_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         rem_q   <= rem_d;
         cnt_q   <= cnt_d;
         valid_q <= valid_d;
         ir_q    <= ir_d;
         pc_q    <= pc_d;
         reg_q   <= reg_d;
         off_q   <= off_d;
         first_q <= first_d;
         last_q  <= last_d;
      end
   end

   assign out_valid  = valid_q;
   assign out_ir     = ir_q;
   assign out_pc     = pc_q;
   assign out_reg    = reg_q;
   assign out_offset = off_q;
   assign out_first  = first_q;
   assign out_last   = last_q;
   assign busy       = (state_q == StSeq);

`ifdef LMSM_PERF_EN
   logic [15:0] perf_q;
   logic        emit_multi;

   assign emit_multi = !flush && !id_stall
                     && ((start && in_multi && enc_any) || (state_q == StSeq));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         perf_q <= '0;
      end else if (emit_multi && (perf_q != 16'hFFFF)) begin
         perf_q <= perf_q + 16'd1;
      end
   end

   assign perf_count = perf_q;
`endif

endmodule

// File: tb/tb_lmsm_sequencer.sv
// Directed bench for lmsm_sequencer: queue-based reference model plus hand-computed literal checks.
module tb_lmsm_sequencer;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic [15:0] in_ir;
   logic [15:0] in_pc;
   logic        id_stall;
   logic        flush;
   logic        out_valid;
   logic [15:0] out_ir;
   logic [15:0] out_pc;
   logic [2:0]  out_reg;
   logic [2:0]  out_offset;
   logic        out_first;
   logic        out_last;
   logic        hold_fetch;
   logic        busy;
`ifdef LMSM_PERF_EN
   logic [15:0] perf_count;
`endif

   int checks = 0;
   int errors = 0;

   lmsm_sequencer dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .in_ir      (in_ir),
      .in_pc      (in_pc),
      .id_stall   (id_stall),
      .flush      (flush),
      .out_valid  (out_valid),
      .out_ir     (out_ir),
      .out_pc     (out_pc),
      .out_reg    (out_reg),
      .out_offset (out_offset),
      .out_first  (out_first),
      .out_last   (out_last),
      .hold_fetch (hold_fetch),
      .busy       (busy)
`ifdef LMSM_PERF_EN
      ,
      .perf_count (perf_count)
`endif
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: pending register indices of the current LM/SM sit in a queue.
   int          pend[$];
   logic [15:0] parent_ir;
   logic        m_valid;
   logic [15:0] m_ir;
   logic [15:0] m_pc;
   int          m_reg;
   int          m_off;
   logic        m_first;
   logic        m_last;

   function automatic logic multi_op(input logic [15:0] ir);
      return (ir[15:12] == 4'h6) || (ir[15:12] == 4'h7);
   endfunction

   task automatic model_emit_next();
      int          r;
      logic [7:0]  oh;
      r        = pend.pop_front();
      oh       = 8'b1 << r;
      m_valid  = 1'b1;
      m_ir     = {parent_ir[15:8], oh};
      m_reg    = r;
      m_last   = (pend.size() == 0);
   endtask

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pend.delete();
         m_valid = 1'b0; m_ir = '0; m_pc = '0; m_reg = 0; m_off = 0;
         m_first = 1'b0; m_last = 1'b0; parent_ir = '0;
      end else if (flush) begin
         pend.delete();
         m_valid = 1'b0;
      end else if (id_stall) begin
         // everything holds
      end else if (pend.size() > 0) begin
         model_emit_next();
         m_off   = m_off + 1;
         m_first = 1'b0;
      end else if (in_valid) begin
         m_pc    = in_pc;
         m_first = 1'b1;
         m_off   = 0;
         if (multi_op(in_ir) && in_ir[7:0] != 8'h00) begin
            parent_ir = in_ir;
            for (int b = 0; b < 8; b++) if (in_ir[b]) pend.push_back(b);
            model_emit_next();
         end else begin
            m_valid = 1'b1;
            m_ir    = in_ir;
            m_reg   = int'(in_ir[11:9]);
            m_last  = 1'b1;
         end
      end else begin
         m_valid = 1'b0;
      end
   end

   always @(negedge clk) begin
      logic exp_hold;
      if (!rst_n) begin
         check("rst_out_valid", 16'(out_valid), 16'h0);
         check("rst_out_ir", out_ir, 16'h0);
         check("rst_busy", 16'(busy), 16'h0);
      end else begin
         exp_hold = id_stall || (pend.size() >= 2)
                  || (pend.size() == 0 && in_valid && multi_op(in_ir)
                      && $countones(in_ir[7:0]) >= 2);
         check("out_valid", 16'(out_valid), 16'(m_valid));
         check("busy", 16'(busy), 16'(pend.size() > 0));
         check("hold_fetch", 16'(hold_fetch), 16'(exp_hold));
         if (m_valid) begin
            check("out_ir", out_ir, m_ir);
            check("out_pc", out_pc, m_pc);
            check("out_reg", 16'(out_reg), 16'(m_reg));
            check("out_offset", 16'(out_offset), 16'(m_off));
            check("out_first", 16'(out_first), 16'(m_first));
            check("out_last", 16'(out_last), 16'(m_last));
         end
      end
   end

   logic hf_seen;

   // Present inputs for one cycle, sample hold_fetch before the edge, return just after it.
   task automatic drive(input logic v, input logic [15:0] ir, input logic [15:0] pc,
                        input logic st, input logic fl);
      in_valid = v; in_ir = ir; in_pc = pc; id_stall = st; flush = fl;
      #2 hf_seen = hold_fetch;
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [15:0] lm_ir [4];
      rst_n = 1'b0; in_valid = 1'b0; in_ir = '0; in_pc = '0; id_stall = 1'b0; flush = 1'b0;
      lm_ir[0] = 16'h6201; lm_ir[1] = 16'h6204; lm_ir[2] = 16'h6220; lm_ir[3] = 16'h6280;
      repeat (2) @(posedge clk);
      #1;
      check("reset_valid", 16'(out_valid), 16'h0);
      check("reset_pc", out_pc, 16'h0);
      check("reset_last", 16'(out_last), 16'h0);
      rst_n = 1'b1;
      drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);

      // ADD pass-through
      drive(1'b1, 16'h0A50, 16'h0010, 1'b0, 1'b0);
      check("add_hold", 16'(hf_seen), 16'h0);
      check("add_valid", 16'(out_valid), 16'h1);
      check("add_ir", out_ir, 16'h0A50);
      check("add_fl", {out_first, out_last}, 16'h3);

      // LM 0x62A5: registers 0,2,5,7
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, 16'h62A5, 16'h0020, 1'b0, 1'b0);
         check("lm_hold", 16'(hf_seen), (i < 3) ? 16'h1 : 16'h0);
         check("lm_ir", out_ir, lm_ir[i]);
         check("lm_off", 16'(out_offset), 16'(i));
         check("lm_last", 16'(out_last), (i == 3) ? 16'h1 : 16'h0);
      end

      // SM with empty mask
      drive(1'b1, 16'h7400, 16'h0030, 1'b0, 1'b0);
      check("sm0_hold", 16'(hf_seen), 16'h0);
      check("sm0_ir", out_ir, 16'h7400);
      check("sm0_fl", {out_first, out_last}, 16'h3);

      // LM 0xFF with a two-cycle stall after the third micro-op
      for (int i = 0; i < 3; i++) drive(1'b1, 16'h62FF, 16'h0034, 1'b0, 1'b0);
      for (int i = 0; i < 2; i++) begin
         drive(1'b1, 16'h62FF, 16'h0034, 1'b1, 1'b0);
         check("stall_reg", 16'(out_reg), 16'h2);
         check("stall_off", 16'(out_offset), 16'h2);
         check("stall_hold", 16'(hf_seen), 16'h1);
      end
      for (int i = 0; i < 5; i++) begin
         drive(1'b1, 16'h62FF, 16'h0034, 1'b0, 1'b0);
         check("ff_reg", 16'(out_reg), 16'(3 + i));
         check("ff_off", 16'(out_offset), 16'(3 + i));
      end
      check("ff_last", 16'(out_last), 16'h1);
      drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);

      // SM 0x0F flushed after its second micro-op
      drive(1'b1, 16'h720F, 16'h0050, 1'b0, 1'b0);
      drive(1'b1, 16'h720F, 16'h0050, 1'b0, 1'b0);
      check("sm_reg1", 16'(out_reg), 16'h1);
      drive(1'b1, 16'h720F, 16'h0050, 1'b0, 1'b1);
      check("flush_valid", 16'(out_valid), 16'h0);
      check("flush_busy", 16'(busy), 16'h0);
      drive(1'b1, 16'h1234, 16'h0060, 1'b0, 1'b0);
      check("post_flush_first", 16'(out_first), 16'h1);
      check("post_flush_ir", out_ir, 16'h1234);

      // Reset mid-sequence
      drive(1'b1, 16'h62A5, 16'h0070, 1'b0, 1'b0);
      drive(1'b1, 16'h62A5, 16'h0070, 1'b0, 1'b0);
      rst_n = 1'b0;
      #1;
      check("midrst_valid", 16'(out_valid), 16'h0);
      check("midrst_ir", out_ir, 16'h0);
      check("midrst_busy", 16'(busy), 16'h0);
      check("midrst_reg", 16'(out_reg), 16'h0);
`ifdef LMSM_PERF_EN
      check("midrst_perf", perf_count, 16'h0);
`endif
      @(posedge clk);
      #1 rst_n = 1'b1;
      for (int i = 0; i < 4; i++) drive(1'b1, 16'h62A5, 16'h0080, 1'b0, 1'b0);
      check("rerun_ir", out_ir, 16'h6280);
      check("rerun_last", 16'(out_last), 16'h1);
`ifdef LMSM_PERF_EN
      check("perf_count", perf_count, 16'h4);
`endif
      drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
      drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
